// File: rtl/bumpy_hit_detect_if.sv
// Pixel-stream and hit-report signals shared by the bumpy collision producer and its consumer.
// The slave side is the hit detector; the master side is the video/stimulus source.
interface bumpy_hit_detect_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        bumpyDrawingRequest;
    logic        stepDrawingRequest;
    logic        singleHitPulse;
    logic [3:0]  HitEdgeCode;
    logic [7:0]  hitPixelCount;

    modport master (
        output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
               bumpyDrawingRequest, stepDrawingRequest,
        input  singleHitPulse, HitEdgeCode, hitPixelCount
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
               bumpyDrawingRequest, stepDrawingRequest,
        output singleHitPulse, HitEdgeCode, hitPixelCount
    );
endinterface

// File: rtl/bumpy_hit_detect.sv
// Detects bumpy/obstacle overlap pixels during a frame, classifies them by sprite edge band,
// and reports the accumulated edge code with a one-cycle pulse after the next startOfFrame.
module bumpy_hit_detect #(
    parameter int OBJ_W      = 32,
    parameter int OBJ_H      = 32,
    parameter int EDGE_W     = 4,
    parameter int MIN_PIXELS = 2
) (
    input  logic               clk,
    input  logic               reset,
    bumpy_hit_detect_if.slave  bus
);
    typedef enum logic [1:0] {ARMED, HIT_SEEN, REPORT} state_t;

    localparam logic signed [11:0] L_ZERO  = 12'sd0;
    localparam logic signed [11:0] L_OBJ_W = 12'(OBJ_W);
    localparam logic signed [11:0] L_OBJ_H = 12'(OBJ_H);
    localparam logic signed [11:0] L_EDGE  = 12'(EDGE_W);
    localparam logic signed [11:0] L_R_LO  = 12'(OBJ_W - EDGE_W);
    localparam logic signed [11:0] L_B_LO  = 12'(OBJ_H - EDGE_W);
    localparam logic [7:0]         L_MIN   = 8'(MIN_PIXELS);

    state_t             r_state;
    state_t             w_nextState;
    logic [3:0]         r_accum;
    logic [7:0]         r_cnt;
    logic               r_pulse;
    logic [3:0]         r_code;
    logic [7:0]         r_count;

    logic signed [11:0] w_offX;
    logic signed [11:0] w_offY;
    logic               w_inX;
    logic               w_inY;
    logic [3:0]         w_bits;
    logic               w_overlap;
    logic               w_report;
    logic               w_qualified;

    // Pixel X is unsigned, sprite origin is signed; extend both into a 12-bit signed offset.
    assign w_offX = $signed({1'b0, bus.pixelX}) - $signed({bus.topLeftX[10], bus.topLeftX});
    assign w_offY = $signed({1'b0, bus.pixelY}) - $signed({bus.topLeftY[10], bus.topLeftY});

    assign w_inX  = (w_offX >= L_ZERO) && (w_offX < L_OBJ_W);
    assign w_inY  = (w_offY >= L_ZERO) && (w_offY < L_OBJ_H);

    assign w_bits[3] = w_inY && (w_offX >= L_ZERO) && (w_offX < L_EDGE);
    assign w_bits[2] = w_inX && (w_offY >= L_ZERO) && (w_offY < L_EDGE);
    assign w_bits[1] = w_inY && (w_offX >= L_R_LO) && (w_offX < L_OBJ_W);
    assign w_bits[0] = w_inX && (w_offY >= L_B_LO) && (w_offY < L_OBJ_H);

    assign w_overlap   = bus.bumpyDrawingRequest && bus.stepDrawingRequest;
    // A startOfFrame arriving while the previous report is still in flight is dropped.
    assign w_report    = bus.startOfFrame && (r_state != REPORT);
    assign w_qualified = (r_cnt >= L_MIN) && (r_accum != 4'b0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARMED;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ARMED: begin
                if (bus.startOfFrame) begin
                    w_nextState = REPORT;
                end else if (w_overlap) begin
                    w_nextState = HIT_SEEN;
                end
            end
            HIT_SEEN: begin
                if (bus.startOfFrame) begin
                    w_nextState = REPORT;
                end
            end
            REPORT: begin
                // A pixel captured together with startOfFrame already opened the new frame.
                w_nextState = (w_overlap || (r_cnt != 8'd0)) ? HIT_SEEN : ARMED;
            end
            default: begin
                w_nextState = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_accum <= 4'b0000;
            r_cnt   <= 8'd0;
        end else if (w_report) begin
            r_accum <= w_overlap ? w_bits : 4'b0000;
            r_cnt   <= w_overlap ? 8'd1 : 8'd0;
        end else if (w_overlap) begin
            if (r_state == ARMED) begin
                r_accum <= w_bits;
                r_cnt   <= 8'd1;
            end else begin
                r_accum <= r_accum | w_bits;
                r_cnt   <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse <= 1'b0;
            r_code  <= 4'b0000;
            r_count <= 8'd0;
        end else begin
            r_pulse <= w_report && w_qualified;
            if (w_report) begin
                r_code  <= w_qualified ? r_accum : 4'b0000;
                r_count <= r_cnt;
            end
        end
    end

    assign bus.singleHitPulse = r_pulse;
    assign bus.HitEdgeCode    = r_code;
    assign bus.hitPixelCount  = r_count;
endmodule

// File: tb/tb_bumpy_hit_detect.sv
// Randomized and directed bench for bumpy_hit_detect, checked every cycle against a
// frame-level reference model of the overlap accumulation and report rules.
module tb_bumpy_hit_detect;
    localparam int OBJ_W      = 32;
    localparam int OBJ_H      = 32;
    localparam int EDGE_W     = 4;
    localparam int MIN_PIXELS = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bumpy_hit_detect_if bus();

    bumpy_hit_detect #(
        .OBJ_W      (OBJ_W),
        .OBJ_H      (OBJ_H),
        .EDGE_W     (EDGE_W),
        .MIN_PIXELS (MIN_PIXELS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int passes = 0;

    int tlx = 0;
    int tly = 0;

    // Reference model: current frame's edge mask and pixel count, plus expected outputs.
    int mAcc = 0;
    int mCnt = 0;
    bit mJustReported = 0;
    int expPulse = 0;
    int expCode = 0;
    int expCount = 0;

    function automatic int edgeBits(input int px, input int py, input int tx, input int ty);
        int ox;
        int oy;
        bit inX;
        bit inY;
        int code;
        ox = px - tx;
        oy = py - ty;
        inX = (ox >= 0) && (ox < OBJ_W);
        inY = (oy >= 0) && (oy < OBJ_H);
        code = 0;
        if (inY && ox >= 0 && ox < EDGE_W)                code += 8;
        if (inX && oy >= 0 && oy < EDGE_W)                code += 4;
        if (inY && ox >= OBJ_W - EDGE_W && ox < OBJ_W)    code += 2;
        if (inX && oy >= OBJ_H - EDGE_W && oy < OBJ_H)    code += 1;
        return code;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit sof, input int px, input int py, input bit bumpy, input bit step);
        bit overlap;
        int bits;
        overlap = bumpy && step;
        bits = edgeBits(px, py, tlx, tly);
        if (sof && !mJustReported) begin
            expPulse = (mCnt >= MIN_PIXELS && mAcc != 0) ? 1 : 0;
            expCode  = expPulse ? mAcc : 0;
            expCount = mCnt;
            mAcc = overlap ? bits : 0;
            mCnt = overlap ? 1 : 0;
            mJustReported = 1;
        end else begin
            expPulse = 0;
            if (overlap) begin
                mAcc = mAcc | bits;
                mCnt = (mCnt < 255) ? mCnt + 1 : 255;
            end
            mJustReported = 0;
        end
    endtask

    task automatic applyStimulus(input bit sof, input int px, input int py, input bit bumpy, input bit step);
        bus.startOfFrame        = sof;
        bus.pixelX              = 11'(px);
        bus.pixelY              = 11'(py);
        bus.topLeftX            = 11'(tlx);
        bus.topLeftY            = 11'(tly);
        bus.bumpyDrawingRequest = bumpy;
        bus.stepDrawingRequest  = step;
        @(posedge clk);
        modelStep(sof, px, py, bumpy, step);
        #1;
        checkOutput("pulse", int'(bus.singleHitPulse), expPulse);
        checkOutput("code",  int'(bus.HitEdgeCode),    expCode);
        checkOutput("count", int'(bus.hitPixelCount),  expCount);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic resetMidCycle();
        #2;
        reset = 1'b1;
        mAcc = 0;
        mCnt = 0;
        mJustReported = 0;
        expPulse = 0;
        expCode = 0;
        expCount = 0;
        #1;
        checkOutput("rst_pulse", int'(bus.singleHitPulse), 0);
        checkOutput("rst_code",  int'(bus.HitEdgeCode),    0);
        checkOutput("rst_count", int'(bus.hitPixelCount),  0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int px;
        int py;
        int stepPct;
        bit sofNext;

        reset = 1'b1;
        bus.startOfFrame        = 1'b0;
        bus.pixelX              = '0;
        bus.pixelY              = '0;
        bus.topLeftX            = '0;
        bus.topLeftY            = '0;
        bus.bumpyDrawingRequest = 1'b0;
        bus.stepDrawingRequest  = 1'b0;
        #3;
        checkOutput("init_pulse", int'(bus.singleHitPulse), 0);
        checkOutput("init_code",  int'(bus.HitEdgeCode),    0);
        checkOutput("init_count", int'(bus.hitPixelCount),  0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a frame discards its overlaps.
        tlx = 100;
        tly = 200;
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 100, 210 + i, 1, 1);
        resetMidCycle();
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t1_pulse", int'(bus.singleHitPulse), 0);
        checkOutput("t1_count", int'(bus.hitPixelCount),  0);
        idle(2);

        // Two left-band pixels qualify and report 1000.
        applyStimulus(0, 100, 215, 1, 1);
        applyStimulus(0, 101, 215, 1, 1);
        idle(3);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t2_pulse", int'(bus.singleHitPulse), 1);
        checkOutput("t2_code",  int'(bus.HitEdgeCode),    8);
        checkOutput("t2_count", int'(bus.hitPixelCount),  2);
        idle(2);

        // Bottom-right corner pixels set two bits.
        applyStimulus(0, 131, 231, 1, 1);
        applyStimulus(0, 130, 230, 1, 1);
        idle(2);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t3_code", int'(bus.HitEdgeCode), 3);
        idle(2);

        // A single pixel is below the glitch filter threshold.
        applyStimulus(0, 100, 215, 1, 1);
        idle(2);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t4_pulse", int'(bus.singleHitPulse), 0);
        checkOutput("t4_count", int'(bus.hitPixelCount),  1);
        idle(2);

        // Overlap coincident with startOfFrame opens the next frame.
        applyStimulus(0, 100, 215, 1, 1);
        applyStimulus(0, 101, 216, 1, 1);
        applyStimulus(1, 110, 201, 1, 1);
        checkOutput("t5_code", int'(bus.HitEdgeCode), 8);
        idle(4);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t5_count", int'(bus.hitPixelCount), 1);
        idle(2);

        // Count saturates at 255.
        for (int i = 0; i < 300; i++) applyStimulus(0, 110, 230, 1, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_code",  int'(bus.HitEdgeCode),   1);
        checkOutput("t6_count", int'(bus.hitPixelCount), 255);
        idle(3);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_empty_code", int'(bus.HitEdgeCode), 0);
        idle(2);

        // Random frames around the sprite, including back-to-back startOfFrame pulses.
        for (int f = 0; f < 30; f++) begin
            tlx = int'($urandom_range(0, 700)) - 60;
            tly = int'($urandom_range(0, 500)) - 60;
            stepPct = int'($urandom_range(0, 40));
            for (int c = 0; c < 40; c++) begin
                px = tlx + int'($urandom_range(0, 40)) - 4;
                py = tly + int'($urandom_range(0, 40)) - 4;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                applyStimulus(0, px, py, $urandom_range(0, 3) != 0,
                              int'($urandom_range(0, 99)) < stepPct);
            end
            sofNext = 1'b1;
            while (sofNext) begin
                px = tlx + int'($urandom_range(0, 40)) - 4;
                py = tly + int'($urandom_range(0, 40)) - 4;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                applyStimulus(1, px, py, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
                sofNext = ($urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 9) == 0) resetMidCycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
